lsu_mmio_controller: RTL and testbench
======================================

# lsu_mmio_controller

Parametrised load/store unit that replaces the fixed single-cycle memory controller between the core's memory stage and data memory. It generates byte enables and aligned write data, sign/zero-extends loads, and decodes a memory-mapped I/O window with a configurable number of output channels and a synchronised switch input. It adds a request/acknowledge handshake to a variable-latency data memory, with pipeline stall, bus timeout and misalignment detection, none of which the previous controller supported.

## Interface
- GPIO_OUT_CH, 2: number of output channels (1-8)
- GPIO_W, 4: width of each output channel and of the switch input (1-8)
- MMIO_BASE, 32'hFFFF_0000: first MMIO address; addresses >= MMIO_BASE are MMIO
- MEM_TIMEOUT, 255: cycles to wait for mem_ack_i before a bus error; 0 disables the timeout
- clk_i  in  1  clock, all logic on the rising edge
- rst_n_i  in  1  synchronous, active-low reset
- req_i  in  1  memory-stage load/store valid; held stable while stall_o is high
- we_i  in  1  1 = store, 0 = load
- funct3_i  in  3  RISC-V size/sign field
- address_i  in  32  byte address (ALU result)
- wdata_i  in  32  store data (rs2), unshifted
- rdata_o  out  32  extended load result, valid in the completing cycle
- stall_o  out  1  hold the fetch-to-memory pipeline
- misaligned_o  out  1  access misaligned, combinational
- bus_err_o  out  1  one-cycle pulse on timeout
- mem_req_o, mem_we_o  out  1  memory request and write strobe
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word-aligned address (bits [1:0] = 0)
- mem_wdata_o  out  32  lane-aligned store data
- mem_ack_i  in  1  memory completes the request this cycle
- mem_rdata_i  in  32  read word, valid with mem_ack_i
- sw_i  in  GPIO_W  asynchronous switch input
- gpio_o  out  GPIO_OUT_CH*GPIO_W  output channels; channel k occupies bits [k*GPIO_W +: GPIO_W]

## Operation
- Size: funct3[1:0] 00 = byte, 01 = half, 10/11 = word. funct3[2] = unsigned load.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - misaligned_o=1 in that cycle; no memory or MMIO access.
  - stall_o=0, rdata_o=0, store dropped.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0], with the byte replicated on all lanes.
  - Half: 4'b0011<<(2*addr[1]), with the half replicated.
  - Word: 4'b1111.
- Loads select the addressed lane, then sign- or zero-extend according to funct3[2].
- MMIO map (offset from MMIO_BASE):
  - 0x00: synchronised switches (read-only, zero-extended).
  - 0x04+4k: output channel k (read/write, low GPIO_W bits).
  - Unmapped offsets read 0; writes to them are ignored.
- MMIO accesses complete combinationally in the request cycle with stall_o=0. Output registers update at that clock edge from wdata_i[GPIO_W-1:0], regardless of size.
- Switch synchroniser: two flops. sw_i reaches the readable value 2 cycles after it changes.
- Memory FSM:
  - IDLE: when req_i is high, the access is aligned and the address is in the memory region, the unit registers address, be, we and wdata, asserts stall_o combinationally and moves to BUS.
  - BUS: mem_req_o=1, stall_o=1, and the timeout counter increments each cycle.
    - On mem_ack_i, the unit captures mem_rdata_i and moves to RESP.
    - If the counter reaches MEM_TIMEOUT with no ack, the unit pulses bus_err_o, sets the captured data to 0 and moves to RESP.
  - RESP: stall_o=0, rdata_o is the extended captured data, next state is IDLE. The pipeline advances on this edge, so the held request is never reissued.
- An ack and a timeout in the same cycle count as an ack; bus_err_o stays 0.
- mem_ack_i outside BUS is ignored.

## Timing
- Reset values: state IDLE, gpio_o=0, synchroniser=0, counter=0. All outputs 0: mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, stall_o, bus_err_o, rdata_o.
- Memory access latency: at least 3 cycles (IDLE → BUS with ack in the first BUS cycle → RESP). stall_o is high for 2 cycles in that case.
- For each extra wait cycle before mem_ack_i, stall_o stays high one more cycle.
- mem_req_o, mem_addr_o, mem_be_o, mem_we_o and mem_wdata_o are registered and stable for every BUS cycle.
- Reset asserted in BUS: the state is IDLE at the next edge and mem_req_o drops. The memory side tolerates an abandoned request.
- When req_i=0, stall_o=0 and nothing changes state.

## Test plan
- SB of 0xA5 to 0x0000_0102 with an immediate ack → mem_be_o=0100, mem_wdata_o=A5A5A5A5, mem_addr_o=0x100, stall_o high for 2 cycles.
- LB/LBU from 0x103 with mem_rdata_i=0x80FF_FF7F → LB returns 0xFFFF_FF80, LBU returns 0x0000_0080; LH from 0x102 returns 0xFFFF_80FF.
- LW with the ack delayed 5 cycles → stall_o high for 6 cycles, rdata_o valid in RESP; with MEM_TIMEOUT=4 and no ack → bus_err_o pulses once, rdata_o=0.
- SW 0x0000_000C to MMIO_BASE+0x08 → gpio_o[7:4]=C in the next cycle with no stall. sw_i=0x5 → a read of MMIO_BASE returns 5 after 2 cycles.
- LW from 0x102 and SH to 0x101 → misaligned_o=1, no mem_req_o, no stall, memory unchanged.
- Reset asserted during BUS → next cycle mem_req_o=0, stall_o=0, state IDLE, gpio_o=0.

Source files
------------

// File: rtl/lsu_mmio_controller.sv
// lsu_mmio_controller: load/store unit between the memory stage and a variable-latency data memory,
// with a memory-mapped GPIO window.
//   clk_i, rst_n_i              clock, synchronous active-low reset
//   req_i/we_i/funct3_i         pipeline access valid, store flag, RISC-V size/sign field
//   address_i/wdata_i/rdata_o   byte address, unshifted store data, extended load result
//   stall_o/misaligned_o        pipeline hold, misaligned access flag
//   bus_err_o                   one-cycle pulse when the memory times out
//   mem_*                       registered request to data memory, ack/rdata back
//   sw_i/gpio_o                 asynchronous switch input, output channels
module lsu_mmio_controller #(
  parameter int          GPIO_OUT_CH = 2,
  parameter int          GPIO_W      = 4,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          MEM_TIMEOUT = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          req_i,
  input  logic                          we_i,
  input  logic [2:0]                    funct3_i,
  input  logic [31:0]                   address_i,
  input  logic [31:0]                   wdata_i,
  output logic [31:0]                   rdata_o,
  output logic                          stall_o,
  output logic                          misaligned_o,
  output logic                          bus_err_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [3:0]                    mem_be_o,
  output logic [31:0]                   mem_addr_o,
  output logic [31:0]                   mem_wdata_o,
  input  logic                          mem_ack_i,
  input  logic [31:0]                   mem_rdata_i,
  input  logic [GPIO_W-1:0]             sw_i,
  output logic [GPIO_OUT_CH*GPIO_W-1:0] gpio_o
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  localparam int CW = $clog2(MEM_TIMEOUT + 2);

  // Select the addressed lane, then sign- or zero-extend (f3[2] = unsigned).
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] lane, input logic [2:0] f3);
    logic [31:0] s;
    s = w >> {lane, 3'b000};
    return f3[1] ? w : f3[0] ? {{16{s[15] & ~f3[2]}}, s[15:0]} : {{24{s[7] & ~f3[2]}}, s[7:0]};
  endfunction

  state_t                             state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [31:0]                        addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
  logic [3:0]                         be_q, be_d;
  logic                               we_q, we_d, err_q, err_d;
  logic [1:0]                         lane_q, lane_d;
  logic [2:0]                         f3_q, f3_d;
  logic [GPIO_OUT_CH-1:0][GPIO_W-1:0] gpio_q, gpio_d;
  logic [GPIO_W-1:0]                  sync1_q, sync1_d, sync2_q, sync2_d;
  logic                               is_half, is_word, is_mmio, access, mmio_acc, mem_acc, tmo;
  logic [29:0]                        widx;
  logic [31:0]                        mmio_rd;

  assign is_half      = funct3_i[1:0] == 2'b01;
  assign is_word      = funct3_i[1];
  assign misaligned_o = req_i & ((is_half & address_i[0]) | (is_word & |address_i[1:0]));
  assign is_mmio      = address_i >= MMIO_BASE;
  // Word index inside the MMIO window; only meaningful when is_mmio.
  assign widx         = address_i[31:2] - MMIO_BASE[31:2];
  // New accesses are only accepted in IDLE; in BUS/RESP req_i is the held memory request.
  assign access       = req_i & ~misaligned_o & (state_q == IDLE);
  assign mmio_acc     = access & is_mmio;
  assign mem_acc      = access & ~is_mmio;
  assign tmo          = (MEM_TIMEOUT != 0) && (cnt_q == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    mmio_rd = (widx == '0) ? 32'(sync2_q) : '0;
    gpio_d  = gpio_q;
    for (int k = 0; k < GPIO_OUT_CH; k++) begin
      if (widx == 30'(k + 1)) begin
        mmio_rd   = 32'(gpio_q[k]);
        gpio_d[k] = (mmio_acc & we_i) ? wdata_i[GPIO_W-1:0] : gpio_q[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    addr_d  = addr_q;
    be_d    = be_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    lane_d  = lane_q;
    f3_d    = f3_q;
    data_d  = data_q;
    err_d   = 1'b0;
    sync1_d = sw_i;
    sync2_d = sync1_q;
    if (mem_acc) begin
      state_d = BUS;
      addr_d  = {address_i[31:2], 2'b00};
      be_d    = is_word ? 4'b1111 : funct3_i[0] ? 4'b0011 << {address_i[1], 1'b0} : 4'b0001 << address_i[1:0];
      we_d    = we_i;
      wdata_d = is_word ? wdata_i : funct3_i[0] ? {2{wdata_i[15:0]}} : {4{wdata_i[7:0]}};
      lane_d  = address_i[1:0];
      f3_d    = funct3_i;
    end else if (state_q == BUS) begin
      cnt_d   = cnt_q + CW'(1);
      state_d = (mem_ack_i | tmo) ? RESP : BUS;
      data_d  = mem_ack_i ? mem_rdata_i : tmo ? '0 : data_q;
      // An ack in the timeout cycle wins.
      err_d   = ~mem_ack_i & tmo;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      lane_q  <= '0;
      f3_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      gpio_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      lane_q  <= lane_d;
      f3_q    <= f3_d;
      data_q  <= data_d;
      err_q   <= err_d;
      gpio_q  <= gpio_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign stall_o     = (state_q == BUS) | mem_acc;
  assign rdata_o     = (state_q == RESP) ? (we_q ? '0 : extend(data_q, lane_q, f3_q)) :
                       (mmio_acc & ~we_i) ? extend(mmio_rd, address_i[1:0], funct3_i) : '0;
  assign bus_err_o   = err_q;
  assign mem_req_o   = state_q == BUS;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign gpio_o      = gpio_q;
endmodule

// File: tb/tb_lsu_mmio_controller.sv
// tb_lsu_mmio_controller: directed self-checking bench; a second instance with MEM_TIMEOUT=4 covers the timeout.
module tb_lsu_mmio_controller;
  logic        clk = 0, rst_n = 0, req = 0, we = 0, ack = 0, ack_t = 0;
  logic [2:0]  f3 = 0;
  logic [31:0] addr = 0, wd = 0, mrd = 0;
  logic [3:0]  sw = 0;
  logic [31:0] d_rdata, d_maddr, d_mwdata, t_rdata, t_maddr, t_mwdata;
  logic        d_stall, d_mis, d_err, d_mreq, d_mwe, t_stall, t_mis, t_err, t_mreq, t_mwe;
  logic [3:0]  d_be, t_be;
  logic [7:0]  d_gpio, t_gpio;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  lsu_mmio_controller dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we), .funct3_i(f3), .address_i(addr),
    .wdata_i(wd), .rdata_o(d_rdata), .stall_o(d_stall), .misaligned_o(d_mis), .bus_err_o(d_err),
    .mem_req_o(d_mreq), .mem_we_o(d_mwe), .mem_be_o(d_be), .mem_addr_o(d_maddr),
    .mem_wdata_o(d_mwdata), .mem_ack_i(ack), .mem_rdata_i(mrd), .sw_i(sw), .gpio_o(d_gpio)
  );

  lsu_mmio_controller #(.MEM_TIMEOUT(4)) dut_t (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we), .funct3_i(f3), .address_i(addr),
    .wdata_i(wd), .rdata_o(t_rdata), .stall_o(t_stall), .misaligned_o(t_mis), .bus_err_o(t_err),
    .mem_req_o(t_mreq), .mem_we_o(t_mwe), .mem_be_o(t_be), .mem_addr_o(t_maddr),
    .mem_wdata_o(t_mwdata), .mem_ack_i(ack_t), .mem_rdata_i(mrd), .sw_i(sw), .gpio_o(t_gpio)
  );

  // Drives one memory access on the main instance, acking after `waits` extra BUS cycles,
  // and returns what was observed; it stops in the RESP cycle.
  task automatic run_mem(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                         input int waits, input logic [31:0] rd, output int stalls, output logic [31:0] res,
                         output logic [3:0] be, output logic [31:0] wdo, output logic [31:0] mad, output logic err);
    int bc;
    @(negedge clk);
    req = 1; we = w; f3 = f; addr = a; wd = d; mrd = rd; ack = 0;
    stalls = 0; bc = 0; be = 0; wdo = 0; mad = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!d_stall) break;
      stalls++;
      if (d_mreq) begin
        bc++;
        be = d_be; wdo = d_mwdata; mad = d_maddr;
        ack = bc > waits;
      end
      @(negedge clk);
    end
    res = d_rdata; err = d_err; ack = 0; req = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; req = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({d_stall, d_mreq, d_mwe, d_err} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {d_stall, d_mreq, d_mwe, d_err});
    end
    checks++;
    if ({d_be, d_maddr, d_mwdata, d_rdata, d_gpio} !== '0) begin
      errors++; $display("FAIL reset_data got be=%h addr=%h wdata=%h rdata=%h gpio=%h want all 0", d_be, d_maddr, d_mwdata, d_rdata, d_gpio);
    end
    rst_n = 1;
  endtask

  task automatic test_store_byte();
    int s; logic [31:0] r, wdo, mad; logic [3:0] be; logic e;
    run_mem(1'b1, 3'b000, 32'h0000_0102, 32'h0000_00A5, 0, 32'h0, s, r, be, wdo, mad, e);
    checks++; if (s !== 2) begin errors++; $display("FAIL sb_stall got %0d want 2", s); end
    checks++; if (be !== 4'b0100) begin errors++; $display("FAIL sb_be got %b want 0100", be); end
    checks++; if (wdo !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata got %h want a5a5a5a5", wdo); end
    checks++; if (mad !== 32'h0000_0100) begin errors++; $display("FAIL sb_addr got %h want 00000100", mad); end
  endtask

  task automatic test_loads();
    int s; logic [31:0] r, wdo, mad; logic [3:0] be; logic e;
    run_mem(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h80FF_FF7F, s, r, be, wdo, mad, e);
    checks++; if (r !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb got %h want ffffff80", r); end
    checks++; if (be !== 4'b1000) begin errors++; $display("FAIL lb_be got %b want 1000", be); end
    run_mem(1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h80FF_FF7F, s, r, be, wdo, mad, e);
    checks++; if (r !== 32'h0000_0080) begin errors++; $display("FAIL lbu got %h want 00000080", r); end
    run_mem(1'b0, 3'b001, 32'h0000_0102, 32'h0, 0, 32'h80FF_FF7F, s, r, be, wdo, mad, e);
    checks++; if (r !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh got %h want ffff80ff", r); end
    checks++; if (be !== 4'b1100) begin errors++; $display("FAIL lh_be got %b want 1100", be); end
  endtask

  task automatic test_delayed_ack();
    int s; logic [31:0] r, wdo, mad; logic [3:0] be; logic e;
    run_mem(1'b0, 3'b010, 32'h0000_0200, 32'h0, 4, 32'h1234_5678, s, r, be, wdo, mad, e);
    checks++; if (s !== 6) begin errors++; $display("FAIL lw_wait_stall got %0d want 6", s); end
    checks++; if (r !== 32'h1234_5678) begin errors++; $display("FAIL lw_wait_rdata got %h want 12345678", r); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL lw_wait_err got %b want 0", e); end
  endtask

  task automatic test_misaligned();
    @(negedge clk); req = 1; we = 0; f3 = 3'b010; addr = 32'h0000_0102; #1;
    checks++;
    if ({d_mis, d_stall, d_rdata} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL lw_mis got mis=%b stall=%b rdata=%h want 1 0 0", d_mis, d_stall, d_rdata);
    end
    @(negedge clk); we = 1; f3 = 3'b001; addr = 32'h0000_0101; wd = 32'hBEEF; #1;
    checks++;
    if ({d_mis, d_stall, d_mreq} !== 3'b100) begin
      errors++; $display("FAIL sh_mis got mis=%b stall=%b mreq=%b want 1 0 0", d_mis, d_stall, d_mreq);
    end
    @(negedge clk); addr = 32'hFFFF_0005; wd = 32'hF; #1;
    checks++;
    if ({d_mis, d_stall, d_mreq} !== 3'b100) begin
      errors++; $display("FAIL sh_mmio_mis got mis=%b stall=%b mreq=%b want 1 0 0", d_mis, d_stall, d_mreq);
    end
    @(negedge clk); req = 0; #1;
    checks++;
    if ({d_mreq, d_gpio} !== 9'h0) begin
      errors++; $display("FAIL mis_noaccess got mreq=%b gpio=%h want 0 00", d_mreq, d_gpio);
    end
  endtask

  task automatic test_mmio();
    @(negedge clk); req = 1; we = 1; f3 = 3'b010; addr = 32'hFFFF_0008; wd = 32'h0000_000C; #1;
    checks++; if (d_stall !== 1'b0) begin errors++; $display("FAIL mmio_stall got %b want 0", d_stall); end
    @(negedge clk); #1;
    checks++; if (d_gpio !== 8'hC0) begin errors++; $display("FAIL mmio_ch1 got %h want c0", d_gpio); end
    f3 = 3'b000; addr = 32'hFFFF_0004; wd = 32'h1234_5603;
    @(negedge clk); #1;
    checks++; if (d_gpio !== 8'hC3) begin errors++; $display("FAIL mmio_ch0_sb got %h want c3", d_gpio); end
    f3 = 3'b010; addr = 32'hFFFF_000C; wd = 32'hF;
    @(negedge clk); #1;
    checks++; if (d_gpio !== 8'hC3) begin errors++; $display("FAIL mmio_unmapped_wr got %h want c3", d_gpio); end
    we = 0; #1;
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL mmio_unmapped_rd got %h want 0", d_rdata); end
    addr = 32'hFFFF_0008; #1;
    checks++;
    if ({d_rdata, d_stall} !== {32'hC, 1'b0}) begin
      errors++; $display("FAIL mmio_rd_ch1 got rdata=%h stall=%b want 0000000c 0", d_rdata, d_stall);
    end
    @(negedge clk); req = 0;
  endtask

  task automatic test_switch();
    @(negedge clk); sw = 4'h5; req = 1; we = 0; f3 = 3'b010; addr = 32'hFFFF_0000; #1;
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL sw_0cyc got %h want 0", d_rdata); end
    @(negedge clk); #1;
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL sw_1cyc got %h want 0", d_rdata); end
    @(negedge clk); #1;
    checks++; if (d_rdata !== 32'h5) begin errors++; $display("FAIL sw_2cyc got %h want 5", d_rdata); end
    req = 0;
  endtask

  task automatic test_timeout();
    int tst, errs, bc; logic done; logic [31:0] tres; logic terr;
    repeat (8) @(negedge clk);
    req = 1; we = 0; f3 = 3'b010; addr = 32'h0000_0200; mrd = 32'hDEAD_BEEF;
    tst = 0; errs = 0; done = 0; tres = 'x; terr = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (t_err) errs++;
      if (!done) begin
        if (t_stall) tst++;
        else begin done = 1; tres = t_rdata; terr = t_err; req = 0; end
      end
      @(negedge clk);
    end
    checks++; if (tst !== 5) begin errors++; $display("FAIL tmo_stall got %0d want 5", tst); end
    checks++; if ({terr, tres} !== {1'b1, 32'h0}) begin errors++; $display("FAIL tmo_resp got err=%b rdata=%h want 1 0", terr, tres); end
    checks++; if (errs !== 1) begin errors++; $display("FAIL tmo_pulses got %0d want 1", errs); end
    req = 1; addr = 32'h0000_0300; mrd = 32'hCAFE_F00D; tst = 0; bc = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!t_stall) break;
      tst++;
      if (t_mreq) begin bc++; ack_t = bc == 4; end
      @(negedge clk);
    end
    checks++;
    if ({tst, t_err, t_rdata} !== {32'd5, 1'b0, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL ack_at_tmo got stall=%0d err=%b rdata=%h want 5 0 cafef00d", tst, t_err, t_rdata);
    end
    ack_t = 0; req = 0;
  endtask

  task automatic test_reset_in_bus();
    @(negedge clk); #1;
    checks++; if (d_mreq !== 1'b1) begin errors++; $display("FAIL bus_hold got mreq=%b want 1", d_mreq); end
    rst_n = 0;
    @(negedge clk); #1;
    checks++;
    if ({d_mreq, d_stall, d_gpio} !== 10'h0) begin
      errors++; $display("FAIL rst_in_bus got mreq=%b stall=%b gpio=%h want 0 0 00", d_mreq, d_stall, d_gpio);
    end
    rst_n = 1; ack = 1;
    @(negedge clk); #1;
    checks++;
    if ({d_mreq, d_stall, d_rdata} !== 34'h0) begin
      errors++; $display("FAIL stray_ack got mreq=%b stall=%b rdata=%h want 0 0 0", d_mreq, d_stall, d_rdata);
    end
    ack = 0;
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_loads();
    test_delayed_ack();
    test_misaligned();
    test_mmio();
    test_switch();
    test_timeout();
    test_reset_in_bus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
